// File: rtl/wb_arbiter_2m_if.sv
// Wishbone B4 classic/registered-burst bundle shared by the arbiter
// and its requesters/target: 32-bit address and data, byte selects.
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter, cyc-level ownership, starve flags.
// WB_ARB_FIXED_PRIO_EN: master 0 always wins contention (else round-robin).
module wb_arbiter_2m #(
  parameter int STARVE_MAX = 255
) (
  input  logic        clk,
  input  logic        rst,
  wshb_if.slave       wb_m0,
  wshb_if.slave       wb_m1,
  wshb_if.master      wb_s,
  output logic [1:0]  grant,
  output logic [1:0]  starve
);

  localparam int CW =
    (STARVE_MAX > 255) ? $clog2(STARVE_MAX + 1) : 8;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   pick1;
  logic [1:0] req;

  assign req = {wb_m1.cyc, wb_m0.cyc};

`ifdef WB_ARB_FIXED_PRIO_EN
  assign pick1 = 1'b0;
`else
  // 1 = master 1 was the most recent owner
  logic last;

  assign pick1 = ~last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (state_nxt != IDLE)
      last <= (state_nxt == OWN1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req == 2'b11)
          state_nxt = pick1 ? OWN1 : OWN0;
        else if (req[0])
          state_nxt = OWN0;
        else if (req[1])
          state_nxt = OWN1;
      end
      OWN0: begin
        if (!req[0])
          state_nxt = req[1] ? OWN1 : IDLE;
      end
      OWN1: begin
        if (!req[1])
          state_nxt = req[0] ? OWN0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant = 2'b00;
    unique case (state)
      OWN0:    grant = 2'b01;
      OWN1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    wb_s.cyc    = 1'b0;
    wb_s.stb    = 1'b0;
    wb_s.we     = 1'b0;
    wb_s.adr    = '0;
    wb_s.dat_ms = '0;
    wb_s.sel    = '0;
    wb_s.cti    = '0;
    wb_s.bte    = '0;
    unique case (1'b1)
      grant[0]: begin
        wb_s.cyc    = wb_m0.cyc;
        wb_s.stb    = wb_m0.stb;
        wb_s.we     = wb_m0.we;
        wb_s.adr    = wb_m0.adr;
        wb_s.dat_ms = wb_m0.dat_ms;
        wb_s.sel    = wb_m0.sel;
        wb_s.cti    = wb_m0.cti;
        wb_s.bte    = wb_m0.bte;
      end
      grant[1]: begin
        wb_s.cyc    = wb_m1.cyc;
        wb_s.stb    = wb_m1.stb;
        wb_s.we     = wb_m1.we;
        wb_s.adr    = wb_m1.adr;
        wb_s.dat_ms = wb_m1.dat_ms;
        wb_s.sel    = wb_m1.sel;
        wb_s.cti    = wb_m1.cti;
        wb_s.bte    = wb_m1.bte;
      end
      default: ;
    endcase
  end

  assign wb_m0.ack    = grant[0] & wb_s.ack;
  assign wb_m0.err    = grant[0] & wb_s.err;
  assign wb_m0.rty    = grant[0] & wb_s.rty;
  assign wb_m1.ack    = grant[1] & wb_s.ack;
  assign wb_m1.err    = grant[1] & wb_s.err;
  assign wb_m1.rty    = grant[1] & wb_s.rty;
  assign wb_m0.dat_sm = wb_s.dat_sm;
  assign wb_m1.dat_sm = wb_s.dat_sm;

  logic [CW-1:0] cnt     [2];
  logic [CW-1:0] cnt_nxt [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_nxt[i] = cnt[i];
      if (!req[i] || grant[i])
        cnt_nxt[i] = '0;
      else if (cnt[i] != SMAX)
        cnt_nxt[i] = cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
      starve <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt[i]    <= cnt_nxt[i];
        starve[i] <= (cnt_nxt[i] == SMAX);
      end
    end
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter: STARVE_MAX, 255, wait cycles (>=1) after which a waiting master raises its starve flag.
REQ-002 Port: clk  input  1  single clock for all logic; the three Wishbone interfaces use this clock.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: wb_m0  wshb_if.slave  bundle  requester 0 (framebuffer reader).
REQ-005 Port: wb_m1  wshb_if.slave  bundle  requester 1 (pattern/CPU writer).
REQ-006 Port: wb_s  wshb_if.master  bundle  shared target (BlockRAM slave).
REQ-007 Port: grant  output  2  one-hot current owner; 2'b00 means no owner.
REQ-008 Port: starve  output  2  bit i set while master i waits >= STARVE_MAX cycles.

Function
REQ-009 A master requests when its cyc is high; the arbiter SHALL implement states IDLE, OWN0, OWN1, with grant = 00/01/10 respectively.
REQ-010 IDLE: on a clock edge with exactly one request, go to that master's OWN state; with both, pick per REQ-014/REQ-024; with none, stay IDLE.
REQ-011 OWNi: stay while wb_mi.cyc is high (bursts, any cti/bte, never preempted); on an edge where wb_mi.cyc is low, go to OWNj if the other master requests, else IDLE (no idle bubble on handover).
REQ-012 Grant latency: a request from IDLE sees its stb at wb_s one cycle after cyc rises; no combinational path from any cyc to grant.
REQ-013 While OWNi: wb_s cyc/stb/we/adr/dat_ms/sel/cti/bte SHALL equal wb_mi's, combinationally; wb_mi.ack/err/rty = wb_s's; wb_mj ack/err/rty = 0.
REQ-014 Default round-robin: on a two-request contention, the master not granted most recently wins; a last-owner register updates on every entry into an OWN state.
REQ-015 In IDLE, wb_s.cyc and wb_s.stb SHALL be 0; other forwarded outputs SHALL be 0.
REQ-016 wb_s.dat_sm SHALL be broadcast to both masters' dat_sm unconditionally.
REQ-017 Starve counter i (8 bits min, saturating at STARVE_MAX) increments each cycle wb_mi.cyc is high and grant[i] is 0; clears when grant[i] is 1 or wb_mi.cyc is 0.
REQ-018 starve[i] is registered and is 1 exactly while counter i equals STARVE_MAX.
REQ-019 A master dropping cyc while waiting (never granted) SHALL be ignored; no grant is issued for it.

Reset
REQ-020 On rst high, asynchronously: state IDLE, grant = 00, last-owner = master 1 (master 0 wins the first contention), starve counters = 0, starve = 00.
REQ-021 rst asserted mid-burst aborts the owner's grant immediately; wb_s.cyc/stb drop in the same cycle; the master must restart after rst deasserts.
REQ-022 After rst deassertion, the first grant occurs no earlier than the first clock edge.

Configuration
REQ-023 Macro WB_ARB_FIXED_PRIO_EN selects the contention policy at compile time.
REQ-024 Defined: master 0 always wins contention, and the last-owner register is not implemented; undefined: round-robin per REQ-014.

Verification
REQ-025 m0 single read, m1 idle -> grant 01 one cycle after m0.cyc rises, m0 receives ack with dat_sm, m1.ack stays 0.
REQ-026 m0 and m1 raise cyc on the same cycle after reset -> grant 01 first; m0 drops cyc -> grant 10 on the next edge with no IDLE cycle; a repeat contention -> m0 wins (round-robin).
REQ-027 m1 in an 8-beat incrementing burst (cti=2, final beat cti=7), m0 requesting throughout -> grant stays 10 for the whole burst, then switches to 01.
REQ-028 STARVE_MAX=4, m1 holds cyc for 10 cycles while m0 waits -> starve[0] rises after the 4th wait cycle and clears the cycle after grant becomes 01.
REQ-029 rst pulsed while grant=01 mid-transfer -> grant 00 and wb_s.cyc 0 immediately, before the next clock edge.
REQ-030 Build with WB_ARB_FIXED_PRIO_EN, repeated two-way contention -> master 0 wins every contention.
